// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}. The operands' signs are applied after the unsigned core finishes.
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CntDone = CW'(DATA_W);

    localparam logic [1:0] StFree   = 2'b00;
    localparam logic [1:0] StByZero = 2'b01;
    localparam logic [1:0] StOn     = 2'b10;
    localparam logic [1:0] StEnd    = 2'b11;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   p_q, p_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic                sgn_q, sgn_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   abs1, abs2, quo_fix, rem_fix;

    // Negation only for signed mode with MSB set, so 0x80000000 stays as its unsigned magnitude.
    assign abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign trial   = {p_q, q_q[DATA_W-1]} - {1'b0, d_q};
    assign quo_fix = (sgn_q && (s1_q ^ s2_q)) ? -q_q : q_q;
    assign rem_fix = (sgn_q && s1_q) ? -p_q : p_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        q_d      = q_q;
        d_d      = d_q;
        sgn_d    = sgn_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            StFree: begin
                if (start_i && !annul_i) begin
                    sgn_d = signed_div_i;
                    s1_d  = opdata1_i[DATA_W-1];
                    s2_d  = opdata2_i[DATA_W-1];
                    if (opdata2_i == '0) begin
                        state_d = StByZero;
                    end else begin
                        state_d = StOn;
                        cnt_d   = '0;
                        p_d     = '0;
                        q_d     = abs1;
                        d_d     = abs2;
                    end
                end
            end
            StByZero: begin
                state_d  = StEnd;
                result_d = '0;
                ready_d  = 1'b1;
            end
            StOn: begin
                if (cnt_q != CntDone) begin
                    if (!trial[DATA_W]) begin
                        p_d = trial[DATA_W-1:0];
                        q_d = {q_q[DATA_W-2:0], 1'b1};
                    end else begin
                        p_d = {p_q[DATA_W-2:0], q_q[DATA_W-1]};
                        q_d = {q_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = StEnd;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            StEnd: begin
                if (!start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = StFree;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase

        // Abort wins over both iteration and a held start.
        if (annul_i && (state_q != StFree)) begin
            state_d  = StFree;
            ready_d  = 1'b0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q  <= StFree;
            cnt_q    <= '0;
            p_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            q_q      <= q_d;
            d_q      <= d_d;
            sgn_q    <= sgn_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for full divisions plus abort and reset sequences.
module tb_div_unit;

    logic        clk;
    logic        Rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_pass;
    int n_total;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    endtask

    // Starts at a negedge, edge 0 samples start; counts edges until ready_o (bounded).
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        // Operands must be ignored once sampled.
        signed_div_i = ~sgn;
        opdata1_i    = ~a;
        opdata2_i    = 32'h0000_0003;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " result"}, result_o, exp);
        @(posedge clk);
        #1;
        check({name, " held"}, {63'd0, ready_o}, 64'd1);
        check({name, " held result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " cleared"}, {63'd0, ready_o}, 64'd0);
        check({name, " cleared result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        n_pass       = 0;
        n_total      = 0;
        Rst_n        = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs[0] = '{"u100/7",        1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33};
        vecs[1] = '{"s-7/2",         1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{"s7/-2",         1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{"uFFFFFFFF/1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33};
        vecs[4] = '{"s-1/1",         1'b1, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33};
        vecs[5] = '{"s_overflow",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33};
        vecs[6] = '{"u5/0",          1'b0, 32'd5,         32'd0,         64'h0, 1};
        vecs[7] = '{"s-100/7",       1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 33};
        vecs[8] = '{"s_min/min",     1'b1, 32'h80000000,  32'h80000000,  64'h00000000_00000001, 33};
        vecs[9] = '{"uFFFFFFFF/8e7", 1'b0, 32'hFFFFFFFF,  32'h80000000,  64'h7FFFFFFF_00000001, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Abort at iteration 10: no result ever appears.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o || result_o != 64'd0) seen++;
        end
        check("annul no result", 64'(seen), 64'd0);
        run_div("u9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Abort while holding a finished result with start still high.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd5;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("byzero ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul in end", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;

        // Synchronous reset at iteration 20.
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        Rst_n   = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("mid reset ready", {63'd0, ready_o}, 64'd0);
        check("mid reset result", result_o, 64'd0);
        @(negedge clk);
        Rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("after reset idle", 64'(seen), 64'd0);
        run_div("u1000/3 after reset", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
